vsmac_stream: RTL and testbench

Streaming, parametrised vector-scalar multiply-accumulate engine with framed dot-product accumulation, requantisation and output backpressure. It is the successor to the fixed 8-bit lane VSMAC:
- lane width, accumulator width, output width, signedness, shift and saturation are generic;
- a valid/ready handshake with a last-beat marker auto-restarts accumulation per vector.

It sits between the weight/activation fetch logic and the activation-function stage of the layer datapath.

---
 rtl/vsmac_stream.sv | 150 +++++++++++++++
 tb/tb_vsmac_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsmac_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vsmac_stream
// Purpose  : Streaming vector-scalar multiply-accumulate engine. Each accepted
//            beat multiplies every lane of vector a by scalar b and adds the
//            product into a per-lane accumulator. The beat flagged in_last
//            closes the dot product: the sum is requantised (shift, then
//            saturate or truncate) into the output register, and the
//            accumulator restarts at zero for the next vector.
// Ports    : clk, reset (sync, active-low)
//            in_valid / in_ready / in_last, a (SIZE lanes, lane 0 in MSBs), b
//            out_valid / out_ready, out_data (SIZE lanes), out_sat
// Revision : 1.0 - initial release
// ============================================================================
module vsmac_stream #(
    parameter int SIZE      = 3,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [SIZE*IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]       b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE*OUT_WIDTH-1:0] out_data,
    output logic                      out_sat
);

    // Clamp limits expressed at accumulator width so comparisons stay exact.
    localparam logic [ACC_WIDTH-1:0] c_umax = ACC_WIDTH'({OUT_WIDTH{1'b1}});
    localparam logic [ACC_WIDTH-1:0] c_smax = ACC_WIDTH'({(OUT_WIDTH-1){1'b1}});
    localparam logic [ACC_WIDTH-1:0] c_smin = ~c_smax;

    logic                 w_adv;
    logic                 w_load;
    logic [SIZE-1:0]      w_clip;
    logic [ACC_WIDTH-1:0] w_bx;
    logic                 r_v1;
    logic                 r_l1;
    logic                 r_out_valid;
    logic                 r_out_sat;

    // The whole pipeline moves only when the output slot is free or draining.
    assign w_adv     = ~r_out_valid | out_ready;
    assign w_load    = r_v1 & r_l1;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;

    // Scalar extended once to accumulator width; the low ACC_WIDTH bits of the
    // extended product equal the sign/zero-extended full product.
    assign w_bx = (SIGNED != 0) ? ACC_WIDTH'($signed(b)) : ACC_WIDTH'(b);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [IN_WIDTH-1:0]  w_a;
        logic [ACC_WIDTH-1:0] w_ax;
        logic [ACC_WIDTH-1:0] w_pext;
        logic [ACC_WIDTH-1:0] w_sum;
        logic [ACC_WIDTH-1:0] w_shr;
        logic [OUT_WIDTH-1:0] w_q;
        logic                 w_lclip;
        logic [ACC_WIDTH-1:0] r_p;
        logic [ACC_WIDTH-1:0] r_acc;
        logic [OUT_WIDTH-1:0] r_q;

        assign w_a    = a[(SIZE-i)*IN_WIDTH-1 -: IN_WIDTH];
        assign w_ax   = (SIGNED != 0) ? ACC_WIDTH'($signed(w_a)) : ACC_WIDTH'(w_a);
        assign w_pext = w_ax * w_bx;
        assign w_sum  = r_acc + r_p;

        if (SIGNED != 0) begin : g_ashr
            assign w_shr = $signed(w_sum) >>> SHIFT;
        end else begin : g_lshr
            assign w_shr = w_sum >> SHIFT;
        end

        always_comb begin
            w_q     = w_shr[OUT_WIDTH-1:0];
            w_lclip = 1'b0;
            if (SATURATE != 0) begin
                if (SIGNED != 0) begin
                    if ($signed(w_shr) > $signed(c_smax)) begin
                        w_q     = c_smax[OUT_WIDTH-1:0];
                        w_lclip = 1'b1;
                    end else if ($signed(w_shr) < $signed(c_smin)) begin
                        w_q     = c_smin[OUT_WIDTH-1:0];
                        w_lclip = 1'b1;
                    end
                end else if (w_shr > c_umax) begin
                    w_q     = c_umax[OUT_WIDTH-1:0];
                    w_lclip = 1'b1;
                end
            end
        end

        assign w_clip[i] = w_lclip;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_p   <= '0;
                r_acc <= '0;
                r_q   <= '0;
            end else if (w_adv) begin
                if (in_valid) begin
                    r_p <= w_pext;
                end
                if (r_v1) begin
                    // Closing beat restarts the accumulator for the next vector.
                    r_acc <= r_l1 ? '0 : w_sum;
                    if (r_l1) begin
                        r_q <= w_q;
                    end
                end
            end
        end

        assign out_data[(SIZE-i)*OUT_WIDTH-1 -: OUT_WIDTH] = r_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1        <= 1'b0;
            r_l1        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_l1 <= in_last;
            end
            // Advancing means the slot is empty or being drained this edge,
            // so the next state is simply whether a new result lands.
            r_out_valid <= w_load;
            if (w_load) begin
                r_out_sat <= |w_clip;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vsmac_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vsmac_stream
// Purpose  : Self-checking bench for vsmac_stream. Four instances share one
//            input stream: (unsigned, sat), (unsigned, wrap), (signed, sat),
//            (signed, shift 1, sat). A queue-based arithmetic model predicts
//            every result; directed checks pin latency, stalls and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vsmac_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [23:0] a = '0;
    logic [7:0]  b = '0;

    logic        in_ready_v [4];
    logic        out_valid_v [4];
    logic [23:0] od [4];
    logic        os [4];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [23:0] d;
        logic        s;
    } exp_t;

    exp_t   q [4][$];
    longint acc_m [4][3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        vsmac_stream #(
            .SIZE      (3),
            .IN_WIDTH  (8),
            .ACC_WIDTH (16),
            .OUT_WIDTH (8),
            .SHIFT     ((k == 3) ? 1 : 0),
            .SIGNED    ((k >= 2) ? 1 : 0),
            .SATURATE  ((k == 1) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[k]),
            .in_last   (in_last),
            .a         (a),
            .b         (b),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready),
            .out_data  (od[k]),
            .out_sat   (os[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_sgn(input int k); return k >= 2; endfunction
    function automatic int m_sh(input int k);  return (k == 3) ? 1 : 0; endfunction
    function automatic bit m_sat(input int k); return k != 1; endfunction

    function automatic longint ext8(input logic [7:0] x, input bit s);
        if (s) return longint'($signed(x));
        return longint'(x);
    endfunction

    // Model: integer dot products, wrapped to 16 bits, then requantised.
    always @(negedge clk) begin
        longint      s;
        longint      r;
        logic [63:0] rb;
        logic [23:0] d;
        logic        any;
        logic [7:0]  x;
        exp_t        e;
        for (int k = 0; k < 4; k++) begin
            if (!reset) begin
                q[k].delete();
                for (int i = 0; i < 3; i++) acc_m[k][i] = 0;
            end else begin
                if (out_valid_v[k]) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("unexpected_out%0d", k), {31'b0, out_valid_v[k]}, 32'd0);
                    end else begin
                        e = q[k][0];
                        chk($sformatf("model_data%0d", k), {8'b0, od[k]}, {8'b0, e.d});
                        chk($sformatf("model_sat%0d", k), {31'b0, os[k]}, {31'b0, e.s});
                        if (out_ready) void'(q[k].pop_front());
                    end
                end
                if (in_valid && in_ready_v[k]) begin
                    for (int i = 0; i < 3; i++) begin
                        x = a[23-8*i -: 8];
                        acc_m[k][i] = (acc_m[k][i] + ext8(x, m_sgn(k)) * ext8(b, m_sgn(k))) & 64'hFFFF;
                    end
                    if (in_last) begin
                        d   = '0;
                        any = 1'b0;
                        for (int i = 0; i < 3; i++) begin
                            s = acc_m[k][i];
                            if (m_sgn(k) && s >= 32768) s = s - 65536;
                            r = s >>> m_sh(k);
                            if (m_sat(k)) begin
                                if (m_sgn(k) && r > 127) begin r = 127; any = 1'b1; end
                                else if (m_sgn(k) && r < -128) begin r = -128; any = 1'b1; end
                                else if (!m_sgn(k) && r > 255) begin r = 255; any = 1'b1; end
                            end
                            rb = r;
                            d[23-8*i -: 8] = rb[7:0];
                            acc_m[k][i] = 0;
                        end
                        e.d = d;
                        e.s = any;
                        q[k].push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] av, input logic [7:0] bv, input bit last);
        int n;
        bit took;
        n    = 0;
        took = 1'b0;
        a        = av;
        b        = bv;
        in_last  = last;
        in_valid = 1'b1;
        while (!took && n < 50) begin
            @(negedge clk);
            took = in_ready_v[0] && reset;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", {31'b0, took}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int k);
        int c;
        c = 0;
        while (!out_valid_v[k] && c < 20) begin
            step();
            c++;
        end
        chk("wait_out", {31'b0, out_valid_v[k]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (3) step();
        chk("rst_valid", {31'b0, out_valid_v[0]}, 32'd0);
        chk("rst_data", {8'b0, od[0]}, 32'd0);
        chk("rst_sat", {31'b0, os[0]}, 32'd0);
        reset = 1'b1;
        step();
        chk("ready_after_rst", {31'b0, in_ready_v[0]}, 32'd1);

        // Three back-to-back beats: latency and single pulse
        send(24'h010407, 8'h01, 1'b0);
        send(24'h020508, 8'h02, 1'b0);
        send(24'h030609, 8'h03, 1'b1);
        chk("lat_early", {31'b0, out_valid_v[0]}, 32'd0);
        step();
        chk("lat_valid", {31'b0, out_valid_v[0]}, 32'd1);
        chk("dot3_data", {8'b0, od[0]}, 32'h0E2032);
        chk("dot3_sat", {31'b0, os[0]}, 32'd0);
        step();
        chk("pulse_end", {31'b0, out_valid_v[0]}, 32'd0);

        // Same beats with gaps, then two single-beat vectors back to back
        send(24'h010407, 8'h01, 1'b0);
        step();
        send(24'h020508, 8'h02, 1'b0);
        step();
        send(24'h030609, 8'h03, 1'b1);
        wait_out(0);
        chk("gap_data", {8'b0, od[0]}, 32'h0E2032);
        send(24'h010203, 8'h02, 1'b1);
        send(24'h040506, 8'h01, 1'b1);
        chk("b2b_valid1", {31'b0, out_valid_v[0]}, 32'd1);
        chk("b2b_data1", {8'b0, od[0]}, 32'h020406);
        step();
        chk("b2b_valid2", {31'b0, out_valid_v[0]}, 32'd1);
        chk("b2b_data2", {8'b0, od[0]}, 32'h040506);
        step();

        // Unsigned saturation vs wrap
        send(24'hFFFF01, 8'hFF, 1'b1);
        step();
        chk("usat_data", {8'b0, od[0]}, 32'hFFFFFF);
        chk("usat_flag", {31'b0, os[0]}, 32'd1);
        chk("uwrap_data", {8'b0, od[1]}, 32'h0101FF);
        chk("uwrap_flag", {31'b0, os[1]}, 32'd0);
        step();

        // Signed saturation, signed shift rounding toward -inf
        send(24'hFF0280, 8'h03, 1'b1);
        step();
        chk("ssat_data", {8'b0, od[2]}, 32'hFD0680);
        chk("ssat_flag", {31'b0, os[2]}, 32'd1);
        step();
        send(24'hFB0A00, 8'h01, 1'b1);
        step();
        chk("sshr_data", {8'b0, od[3]}, 32'hFD0500);
        chk("sshr_flag", {31'b0, os[3]}, 32'd0);
        step();

        // Backpressure: first result stalls, second vector held in stage 1
        out_ready = 1'b0;
        send(24'h010203, 8'h03, 1'b1);
        send(24'h020202, 8'h02, 1'b1);
        chk("bp_ready", {31'b0, in_ready_v[0]}, 32'd0);
        chk("bp_data", {8'b0, od[0]}, 32'h030609);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", {31'b0, out_valid_v[0]}, 32'd1);
            chk("bp_hold_data", {8'b0, od[0]}, 32'h030609);
            chk("bp_hold_ready", {31'b0, in_ready_v[0]}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_second_valid", {31'b0, out_valid_v[0]}, 32'd1);
        chk("bp_second_data", {8'b0, od[0]}, 32'h040404);
        step();
        chk("bp_drained", {31'b0, out_valid_v[0]}, 32'd0);

        // Reset mid-vector discards the partial sum; beats during reset drop
        send(24'h010101, 8'h01, 1'b0);
        send(24'h010101, 8'h01, 1'b0);
        reset    = 1'b0;
        a        = 24'h7F7F7F;
        b        = 8'h01;
        in_last  = 1'b1;
        in_valid = 1'b1;
        step();
        chk("midrst_valid", {31'b0, out_valid_v[0]}, 32'd0);
        chk("midrst_data", {8'b0, od[0]}, 32'd0);
        chk("midrst_sat", {31'b0, os[0]}, 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b1;
        step();
        send(24'h020202, 8'h01, 1'b1);
        step();
        chk("post_rst_valid", {31'b0, out_valid_v[0]}, 32'd1);
        chk("post_rst_data", {8'b0, od[0]}, 32'h020202);

        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), q[k].size(), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
